// File: rtl/draw_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// draw_cmd_arbiter
//
// Round-robin arbiter and sequencer between two span-command sources (e.g. CPU
// and sprite engine) and the draw unit's two-word command write port. A granted
// command is latched, then written as word0 = {6'b0, y, color} followed by
// word1 = {x0, x1}. Words from different sources are never interleaved.
//
// Optional feature macro: DRAW_ARB_CLIP_EN
//   defined   : x0/x1 clamped to X_MAX and ordered; rows above Y_MAX are
//               accepted but discarded, with a one-cycle dropped pulse.
//   undefined : fields pass through unchanged; dropped is always 0.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   reqN_valid/y/color/   command from requester N (N = 0,1)
//   x0/x1
//   reqN_ready            command N accepted this cycle
//   we, data, full        write strobe, command word, draw-unit FIFO full
//   busy                  command latched and not yet fully written
//   grant                 index of the most recently accepted requester
//   dropped               one-cycle pulse when a command is clipped away
//   state_dbg             current FSM state (IDLE=0, WORD0=1, WORD1=2)
//
// Handshake: a requester holds valid and its fields stable until it sees
// ready high; ready is combinational, only ever high in IDLE, and the command
// transfers on the rising edge of the cycle in which valid && ready.
// -----------------------------------------------------------------------------
module draw_cmd_arbiter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [6:0]  req0_y,
  input  logic [2:0]  req0_color,
  input  logic [7:0]  req0_x0,
  input  logic [7:0]  req0_x1,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [6:0]  req1_y,
  input  logic [2:0]  req1_color,
  input  logic [7:0]  req1_x0,
  input  logic [7:0]  req1_x1,
  output logic        req1_ready,
  output logic        we,
  output logic [15:0] data,
  input  logic        full,
  output logic        busy,
  output logic        grant,
  output logic        dropped,
  output logic [1:0]  state_dbg
);

`ifdef DRAW_ARB_CLIP_EN
  localparam logic LP_CLIP_EN = 1'b1;
`else
  localparam logic LP_CLIP_EN = 1'b0;
`endif

  localparam logic [7:0] LP_X_MAX = 8'(X_MAX);
  localparam logic [6:0] LP_Y_MAX = 7'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WORD0 = 2'd1,
    S_WORD1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [6:0]  r_y;
  logic [2:0]  r_color;
  logic [7:0]  r_x0;
  logic [7:0]  r_x1;
  logic        r_grant;
  logic        r_dropped;

  logic        w_idle;
  logic        w_accept;
  logic        w_win;
  logic [6:0]  w_y;
  logic [2:0]  w_color;
  logic [7:0]  w_x0;
  logic [7:0]  w_x1;
  logic [7:0]  w_x0_cl;
  logic [7:0]  w_x1_cl;
  logic        w_swap;
  logic [7:0]  w_x0_fin;
  logic [7:0]  w_x1_fin;
  logic        w_drop;

  // Arbitration and field selection for the command being accepted.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_accept = w_idle && (req0_valid || req1_valid);
    // On a tie the requester that did not win last time goes next.
    w_win    = (req0_valid && req1_valid) ? ~r_grant : req1_valid;

    w_y      = w_win ? req1_y     : req0_y;
    w_color  = w_win ? req1_color : req0_color;
    w_x0     = w_win ? req1_x0    : req0_x0;
    w_x1     = w_win ? req1_x1    : req0_x1;

    // Clamp first, then order, so a clamped x0 can still be swapped.
    w_x0_cl  = (LP_CLIP_EN && (w_x0 > LP_X_MAX)) ? LP_X_MAX : w_x0;
    w_x1_cl  = (LP_CLIP_EN && (w_x1 > LP_X_MAX)) ? LP_X_MAX : w_x1;
    w_swap   = LP_CLIP_EN && (w_x0_cl > w_x1_cl);
    w_x0_fin = w_swap ? w_x1_cl : w_x0_cl;
    w_x1_fin = w_swap ? w_x0_cl : w_x1_cl;
    w_drop   = LP_CLIP_EN && (w_y > LP_Y_MAX);

    req0_ready = w_accept && !w_win;
    req1_ready = w_accept &&  w_win;
  end

  // Next-state and write-port outputs.
  always_comb begin
    w_next_state = r_state;
    we           = 1'b0;
    data         = 16'h0000;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_drop) w_next_state = S_WORD0;
      end
      S_WORD0: begin
        busy = 1'b1;
        we   = !full;
        data = {6'b0, r_y, r_color};
        if (!full) w_next_state = S_WORD1;
      end
      S_WORD1: begin
        busy = 1'b1;
        we   = !full;
        data = {r_x0, r_x1};
        if (!full) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_y       <= '0;
      r_color   <= '0;
      r_x0      <= '0;
      r_x1      <= '0;
      r_grant   <= 1'b1;  // req0 wins the first tie after reset
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_dropped <= w_accept && w_drop;
      if (w_accept) begin
        r_y     <= w_y;
        r_color <= w_color;
        r_x0    <= w_x0_fin;
        r_x1    <= w_x1_fin;
        r_grant <= w_win;
      end
    end
  end

  assign grant     = r_grant;
  assign dropped   = r_dropped;
  assign state_dbg = r_state;

endmodule
